// File: rtl/id_ex_stage.sv
// ============================================================================
// Module   : id_ex_stage
// Brief    : ID/EX pipeline register with load-use hazard bubbles,
//            redirect squash (delayed_flush) and a saturating bubble counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_stall,
    input  logic             ex_redirect,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [2:0]       id_funct3,
    input  logic             id_funct7b5,
    input  logic             id_attempt_branch,
    input  logic             id_is_jalr,
    input  logic             id_jump,
    input  logic             id_reg_write,
    input  logic             id_mem_to_reg,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_immediate,
    input  logic             id_auipc,
    input  logic [2:0]       id_alu_op,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [2:0]       ex_funct3,
    output logic             ex_funct7b5,
    output logic             ex_attempt_branch,
    output logic             ex_is_jalr,
    output logic             ex_jump,
    output logic             ex_reg_write,
    output logic             ex_mem_to_reg,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_immediate,
    output logic             ex_auipc,
    output logic [2:0]       ex_alu_op,
    output logic             stall_fetch,
    output logic             delayed_flush,
    output logic [CNT_W-1:0] bubble_count
);

    logic w_rs1_match;
    logic w_rs2_match;
    logic w_hazard;
    logic w_bubble;
    logic w_count_bubble;
    logic w_cnt_sat;

    // Load-use: a load in EX whose destination decode needs; x0 never counts.
    assign w_rs1_match    = id_uses_rs1 && (id_rs1 == ex_rd);
    assign w_rs2_match    = id_uses_rs2 && (id_rs2 == ex_rd);
    assign w_hazard       = ex_valid && ex_mem_read && (ex_rd != 5'd0) && id_valid
                            && (w_rs1_match || w_rs2_match);
    assign stall_fetch    = w_hazard && !ex_redirect && !mem_stall;
    assign w_bubble       = ex_redirect || w_hazard || !id_valid;
    assign w_count_bubble = ex_redirect || w_hazard;
    assign w_cnt_sat      = &bubble_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid          <= 1'b0;
            ex_pc             <= '0;
            ex_rs1_data       <= '0;
            ex_rs2_data       <= '0;
            ex_imm            <= '0;
            ex_rs1            <= '0;
            ex_rs2            <= '0;
            ex_rd             <= '0;
            ex_funct3         <= '0;
            ex_funct7b5       <= 1'b0;
            ex_attempt_branch <= 1'b0;
            ex_is_jalr        <= 1'b0;
            ex_jump           <= 1'b0;
            ex_reg_write      <= 1'b0;
            ex_mem_to_reg     <= 1'b0;
            ex_mem_read       <= 1'b0;
            ex_mem_write      <= 1'b0;
            ex_immediate      <= 1'b0;
            ex_auipc          <= 1'b0;
            ex_alu_op         <= '0;
            delayed_flush     <= 1'b0;
            bubble_count      <= '0;
        end else if (!mem_stall) begin
            if (w_bubble) begin
                // Full bubble: zero every field so nothing can leak into EX.
                ex_valid          <= 1'b0;
                ex_pc             <= '0;
                ex_rs1_data       <= '0;
                ex_rs2_data       <= '0;
                ex_imm            <= '0;
                ex_rs1            <= '0;
                ex_rs2            <= '0;
                ex_rd             <= '0;
                ex_funct3         <= '0;
                ex_funct7b5       <= 1'b0;
                ex_attempt_branch <= 1'b0;
                ex_is_jalr        <= 1'b0;
                ex_jump           <= 1'b0;
                ex_reg_write      <= 1'b0;
                ex_mem_to_reg     <= 1'b0;
                ex_mem_read       <= 1'b0;
                ex_mem_write      <= 1'b0;
                ex_immediate      <= 1'b0;
                ex_auipc          <= 1'b0;
                ex_alu_op         <= '0;
                delayed_flush     <= ex_redirect;
                if (w_count_bubble && !w_cnt_sat) begin
                    bubble_count <= bubble_count + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end else begin
                ex_valid          <= 1'b1;
                ex_pc             <= id_pc;
                ex_rs1_data       <= id_rs1_data;
                ex_rs2_data       <= id_rs2_data;
                ex_imm            <= id_imm;
                ex_rs1            <= id_rs1;
                ex_rs2            <= id_rs2;
                ex_rd             <= id_rd;
                ex_funct3         <= id_funct3;
                ex_funct7b5       <= id_funct7b5;
                ex_attempt_branch <= id_attempt_branch;
                ex_is_jalr        <= id_is_jalr;
                ex_jump           <= id_jump;
                ex_reg_write      <= id_reg_write;
                ex_mem_to_reg     <= id_mem_to_reg;
                ex_mem_read       <= id_mem_read;
                ex_mem_write      <= id_mem_write;
                ex_immediate      <= id_immediate;
                ex_auipc          <= id_auipc;
                ex_alu_op         <= id_alu_op;
                delayed_flush     <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between decode and execute.
- Captures the control bundle produced by the opcode decoder, together with decode operands.
- Detects load-use hazards and inserts bubbles for them and for EX-stage redirects.
- Generates the registered delayed_flush that squashes the instruction in decode one cycle after a redirect.

Parameters:
- XLEN, 32, datapath width of pc/operand/immediate fields.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_stall  in  1  data-memory busy; freezes all state in this block.
- ex_redirect  in  1  taken branch or jump resolved in EX this cycle; sampled only when mem_stall=0.
- id_valid  in  1  decode holds a real instruction.
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each  decode datapath fields.
- id_rs1, id_rs2, id_rd  in  5 each  register indices.
- id_uses_rs1, id_uses_rs2  in  1 each  instruction reads that source.
- id_funct3  in  3  funct3 field.
- id_funct7b5  in  1  instruction bit 30.
- id_attempt_branch, id_is_jalr, id_jump, id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_immediate, id_auipc  in  1 each  decoder control bundle.
- id_alu_op  in  3  ALU operation class.
- ex_valid  out  1  EX holds a real instruction.
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN each  registered fields.
- ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5  out  5/5/5/3/1  registered fields.
- ex_attempt_branch … ex_auipc, ex_alu_op  out  1 (ex_alu_op: 3)  registered control bundle.
- stall_fetch  out  1  combinational: hold PC and the IF/ID register this cycle.
- delayed_flush  out  1  registered: squash the decode instruction next cycle.
- bubble_count  out  CNT_W  saturating count of inserted hazard/redirect bubbles.

Behaviour:
- Reset (asynchronous, any time, including mid-stall): every registered output = 0. This covers ex_valid, all data fields, all control fields, delayed_flush and bubble_count.
- hazard (combinational) = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- stall_fetch = hazard & ~ex_redirect & ~mem_stall. A redirect squashes decode, so no stall is needed when ex_redirect=1.
- Per-edge update, first match wins:
  1. mem_stall=1: hold all registers, including delayed_flush and bubble_count.
  2. ex_redirect=1: insert bubble; delayed_flush <= 1; bubble_count += 1.
  3. hazard=1: insert bubble; delayed_flush <= 0; bubble_count += 1.
  4. id_valid=0: insert bubble; delayed_flush <= 0; bubble_count unchanged.
  5. Otherwise: capture all id_* fields into ex_*; ex_valid <= 1; delayed_flush <= 0.
- Bubble: ex_valid = 0, every control output = 0 and every data/index field = 0. No write, memory access, branch or jump can leak.
- Latency: one cycle from decode to EX outputs. delayed_flush is high for exactly the one unstalled cycle following a sampled redirect. If mem_stall follows that cycle, delayed_flush stays high until the stall releases.
- The load-use stall lasts exactly one cycle. The bubble clears ex_mem_read, so the hazard drops on the next edge and the held instruction then advances.
- bubble_count saturates at 2^CNT_W-1 and never wraps.
- Load to rd=x0 never stalls.
- A source with uses=0 never stalls even if its index matches.

Test Plan:
- Assert rst mid-stream with ex_valid=1, delayed_flush=1, bubble_count=5 → all outputs 0 immediately (before the next edge) and remain 0 while rst=1.
- Load x5 in EX (ex_mem_read=1, ex_rd=5); decode add with id_rs2=5, id_uses_rs2=1 → stall_fetch=1 that cycle; next edge ex_valid=0, bubble_count=1; following edge the add captured, ex_valid=1, stall_fetch=0.
- Load x0 in EX; decode reads rs1=0 → stall_fetch=0; the instruction is captured directly and bubble_count is unchanged.
- ex_redirect=1 with a hazard also present → stall_fetch=0; next edge ex_valid=0, delayed_flush=1; one edge later delayed_flush=0.
- mem_stall=1 for 3 cycles while ex_redirect=1 and id_valid=1 → all ex_* outputs, delayed_flush and bubble_count unchanged across the 3 edges; redirect takes effect only on the first edge with mem_stall=0.
- CNT_W=4: force 17 redirect bubbles → bubble_count reaches 15 and stays 15.
